// File: rtl/othello_move_ctrl.sv
// Executes one Othello move on the board RAM: checks the origin, scans eight directions, flips runs, then places.
// Latency 2 + 2/scanned cell + 1/flip + 1 (place, legal only) + 1 (done); start is ignored while busy.
module othello_move_ctrl #(
   parameter int BW = 7,
   parameter int CW = 5
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic [BW-1:0] move_addr_i,
   input  logic          player_i,
   input  logic [1:0]    mem_rdata_i,
   output logic [BW-1:0] mem_addr_o,
   output logic [1:0]    mem_wdata_o,
   output logic          mem_wren_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          valid_o,
   output logic [CW-1:0] flip_count_o
);

   typedef enum logic [2:0] {
      IDLE, RD_ORIG, CHK_ORIG, SCAN_RD, SCAN_CHK, FLIP, PLACE, DONE
   } state_t;

   state_t        state_q;
   logic [BW-1:0] origin_q, pos_q, mem_addr_q;
   logic [1:0]    own_q, mem_wdata_q;
   logic [2:0]    dir_q, run_q;
   logic [CW-1:0] flip_count_q;
   logic          valid_q, done_q, busy_q, mem_wren_q;

   // Direction offsets wrap modulo 2^BW, so subtraction walks back toward the origin.
   function automatic logic [BW-1:0] dir_off(input logic [2:0] d);
      case (d)
         3'd0:    dir_off = BW'(-11);
         3'd1:    dir_off = BW'(-10);
         3'd2:    dir_off = BW'(-9);
         3'd3:    dir_off = BW'(-1);
         3'd4:    dir_off = BW'(1);
         3'd5:    dir_off = BW'(9);
         3'd6:    dir_off = BW'(10);
         default: dir_off = BW'(11);
      endcase
   endfunction

   logic [2:0]    dir_nxt_d;
   logic [BW-1:0] pos_fwd_d, pos_bck_d, adv_pos_d;
   logic [1:0]    opp_d;

   assign dir_nxt_d = dir_q + 3'd1;
   assign pos_fwd_d = pos_q + dir_off(dir_q);
   assign pos_bck_d = pos_q - dir_off(dir_q);
   assign adv_pos_d = origin_q + dir_off(dir_nxt_d);
   assign opp_d     = ~own_q;

   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign mem_wren_o   = mem_wren_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign valid_o      = valid_q;
   assign flip_count_o = flip_count_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         origin_q     <= '0;
         pos_q        <= '0;
         own_q        <= 2'b01;
         dir_q        <= '0;
         run_q        <= '0;
         flip_count_q <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wren_q   <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         mem_wren_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  origin_q     <= move_addr_i;
                  own_q        <= player_i ? 2'b10 : 2'b01;
                  valid_q      <= 1'b0;
                  flip_count_q <= '0;
                  run_q        <= '0;
                  dir_q        <= '0;
                  mem_addr_q   <= move_addr_i;
                  busy_q       <= 1'b1;
                  state_q      <= RD_ORIG;
               end
            end
            RD_ORIG: state_q <= CHK_ORIG;
            CHK_ORIG: begin
               if (mem_rdata_i != 2'b00) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  pos_q      <= origin_q + dir_off(3'd0);
                  mem_addr_q <= origin_q + dir_off(3'd0);
                  run_q      <= '0;
                  state_q    <= SCAN_RD;
               end
            end
            SCAN_RD: state_q <= SCAN_CHK;
            SCAN_CHK: begin
               if (mem_rdata_i == opp_d) begin
                  run_q      <= run_q + 3'd1;
                  pos_q      <= pos_fwd_d;
                  mem_addr_q <= pos_fwd_d;
                  state_q    <= SCAN_RD;
               end else if (mem_rdata_i == own_q && run_q != 3'd0) begin
                  pos_q       <= pos_bck_d;
                  mem_addr_q  <= pos_bck_d;
                  mem_wdata_q <= own_q;
                  mem_wren_q  <= 1'b1;
                  state_q     <= FLIP;
               end else if (dir_q != 3'd7) begin
                  dir_q      <= dir_nxt_d;
                  pos_q      <= adv_pos_d;
                  mem_addr_q <= adv_pos_d;
                  run_q      <= '0;
                  state_q    <= SCAN_RD;
               end else if (flip_count_q != '0) begin
                  mem_addr_q  <= origin_q;
                  mem_wdata_q <= own_q;
                  mem_wren_q  <= 1'b1;
                  state_q     <= PLACE;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            FLIP: begin
               flip_count_q <= flip_count_q + CW'(1);
               run_q        <= run_q - 3'd1;
               if (run_q != 3'd1) begin
                  pos_q      <= pos_bck_d;
                  mem_addr_q <= pos_bck_d;
                  mem_wren_q <= 1'b1;
               end else if (dir_q != 3'd7) begin
                  dir_q      <= dir_nxt_d;
                  pos_q      <= adv_pos_d;
                  mem_addr_q <= adv_pos_d;
                  run_q      <= '0;
                  state_q    <= SCAN_RD;
               end else begin
                  // At least one flip has just been written, so the move is legal.
                  mem_addr_q <= origin_q;
                  mem_wren_q <= 1'b1;
                  state_q    <= PLACE;
               end
            end
            PLACE: begin
               valid_q <= 1'b1;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
